rr_arbiter_16: RTL
==================

// Module: rr_arbiter_16
// PURPOSE
//  Round-robin arbiter sharing one resource among 16 requesters. It produces a
//  registered 4-bit grant index plus its one-hot expansion (4-to-16 decode, bit i =
//  index i) for driving per-requester enables. It is the sequencing/sharing block
//  placed in front of the 4-to-16 select decode path.
// PARAMETERS
//  N_REQ     16  number of requesters; fixed, index width is 4
//  IDX_W     4   grant index width; fixed, log2(N_REQ)
//  MAX_HOLD  8   max consecutive grant cycles (used only with HOLD_TIMEOUT_EN); 1..255
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  req         in   16  request vector; bit i held high while requester i wants/uses resource
//  gnt_vld     out  1   a grant is active
//  gnt_idx     out  4   index of granted requester (valid when gnt_vld=1)
//  gnt_onehot  out  16  one-hot of gnt_idx when gnt_vld=1, else all zero
//  timeout     out  1   1-cycle pulse: grant revoked by hold timeout (0 if macro off)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, gnt_vld=0, gnt_idx=0, gnt_onehot=0,
//    timeout=0, last pointer=15 (requester 0 has top priority first), hold counter=0.
//  - All outputs are registered. Onehot equals decode(gnt_idx) gated by gnt_vld.
//  - FSM states: IDLE, GRANT.
//    IDLE: if req!=0, select the first set bit searching last+1, last+2, ... wrapping
//      15->0. Register gnt_idx=sel, gnt_vld=1, set last=sel, go GRANT.
//      If req==0, stay IDLE with outputs at 0.
//    GRANT: while req[gnt_idx]=1 (and no timeout), hold the grant unchanged.
//      If req[gnt_idx]=0 at a clock edge, clear gnt_vld and gnt_onehot, then go IDLE.
//  - Latency: req rising at edge t (from IDLE) -> gnt_vld=1 after edge t+1.
//    Release -> re-grant takes min 2 edges (one IDLE cycle with gnt_vld=0 between
//    grants). Back-to-back grants are never made to two indices without that gap.
//  - Fairness: last pointer updates only when a grant is issued. A requester that
//    just held the grant has lowest priority in the next arbitration.
//  - Non-granted req bits changing during GRANT have no effect. A glitch-free held
//    req on the owner keeps the grant indefinitely (macro off).
//  - gnt_idx holds its last value in IDLE (gnt_vld=0), so consumers must qualify with gnt_vld.
//  - Reset asserted in GRANT: all outputs drop asynchronously to 0 and the pointer
//    returns to 15.
// CONFIGURATION
//  HOLD_TIMEOUT_EN defined:
//    - An 8-bit hold counter is cleared on grant and incremented each GRANT cycle.
//    - After the grant has been high for MAX_HOLD cycles: revoke it (gnt_vld=0),
//      pulse timeout=1 for one cycle, go IDLE.
//    - The revoked requester keeps its req high and is re-arbitrated at lowest priority.
//    - If the owner drops req on the same edge the counter expires, treat it as a
//      normal release (timeout=0).
//  HOLD_TIMEOUT_EN undefined: no counter logic, timeout tied 0, grant held until release.
// TESTING
//  1 Reset: rst_n=0 with req=16'hFFFF -> all outputs 0. Release reset -> after 1 edge
//    gnt_idx=0, gnt_onehot=16'h0001, gnt_vld=1.
//  2 Rotation: req=16'h8421 held, each owner drops/reasserts after 3 cycles ->
//    grant order 0,5,10,15,0 with one gnt_vld=0 cycle between each.
//  3 Wrap: last=15, req=16'h0003 -> grants 0 then 1 then 0. Single req bit 7 only ->
//    repeated grants to 7.
//  4 Reset mid-grant: gnt_idx=9 active, pulse rst_n low between edges -> outputs 0
//    immediately. After release with req=16'h0200 -> gnt_idx=9 again after 1 edge.
//  5 Timeout (HOLD_TIMEOUT_EN, MAX_HOLD=8): req=16'h0011 held -> idx 0 for 8 cycles,
//    timeout pulse, IDLE cycle, then idx 4 for 8 cycles, then idx 0.
//  6 Timeout/release tie: owner drops req on the expiry edge -> timeout stays 0.
//    Macro off: same stimulus as 5 -> idx 0 held indefinitely, timeout never 1.

Source files
------------

// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - 16-way round-robin arbiter with registered index and one-hot grant
// Optional hold limit enabled by defining HOLD_TIMEOUT_EN (parameter MAX_HOLD).
module rr_arbiter_16 #(
   parameter int N_REQ = 16,
   parameter int IDX_W = 4
`ifdef HOLD_TIMEOUT_EN
   , parameter int MAX_HOLD = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic             gnt_vld,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic             timeout
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t             state_q, state_d;
   logic               vld_q, vld_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [N_REQ-1:0]   onehot_q, onehot_d;
   logic [IDX_W-1:0]   sel;
   logic [IDX_W-1:0]   cand;
`ifdef HOLD_TIMEOUT_EN
   logic [7:0]         hold_q, hold_d;
   logic               timeout_q, timeout_d;
`endif

   // Walk from the farthest candidate back to last+1 so the nearest set bit wins.
   always_comb begin
      sel  = last_q;
      cand = last_q;
      for (int i = N_REQ; i >= 1; i--) begin
         cand = last_q + IDX_W'(i);
         if (req[cand]) sel = cand;
      end
   end

   always_comb begin
      state_d  = state_q;
      vld_d    = vld_q;
      idx_d    = idx_q;
      last_d   = last_q;
      onehot_d = onehot_q;
`ifdef HOLD_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d  = S_GRANT;
               vld_d    = 1'b1;
               idx_d    = sel;
               last_d   = sel;
               onehot_d = N_REQ'(1) << sel;
`ifdef HOLD_TIMEOUT_EN
               hold_d   = 8'd0;
`endif
            end
         end
         S_GRANT: begin
            // A release on the expiry edge takes precedence, so no timeout pulse then.
            if (!req[idx_q]) begin
               state_d  = S_IDLE;
               vld_d    = 1'b0;
               onehot_d = '0;
            end
`ifdef HOLD_TIMEOUT_EN
            else if (hold_q == 8'(MAX_HOLD - 1)) begin
               state_d   = S_IDLE;
               vld_d     = 1'b0;
               onehot_d  = '0;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d  = S_IDLE;
            vld_d    = 1'b0;
            onehot_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         vld_q    <= 1'b0;
         idx_q    <= '0;
         last_q   <= '1;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         vld_q    <= vld_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         onehot_q <= onehot_d;
      end
   end

`ifdef HOLD_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign gnt_vld    = vld_q;
   assign gnt_idx    = idx_q;
   assign gnt_onehot = onehot_q;

endmodule
